// File: rtl/jogador_pkg.sv
// rtl/jogador_pkg.sv - shared state encoding and width helpers for the automatic player
package jogador_pkg;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    OBSERVA   = 3'd1,
    PRESSIONA = 3'd2,
    SOLTA     = 3'd3,
    FIM       = 3'd4
  } estado_t;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int largura(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int maior3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/jogador_automatico_memoria.sv
// rtl/jogador_automatico_memoria.sv - DEPTH x 4 pattern store, synchronous write, combinational read
module memoria_jogadas #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] endereco_escrita,
  input  logic [3:0]    dado,
  input  logic [AW-1:0] endereco_leitura,
  output logic [3:0]    dado_lido
);

  logic [3:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem_q[endereco_escrita] <= dado;
  end

  assign dado_lido = mem_q[endereco_leitura];

endmodule

// File: rtl/jogador_automatico.sv
// rtl/jogador_automatico.sv - records the LED sequence of a round and replays it as button presses
module jogador_automatico
  import jogador_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int PRESS_CYCLES = 1000,
  parameter int GAP_CYCLES   = 1000,
  parameter int IDLE_CYCLES  = 3000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   habilita,
  input  logic [3:0]             leds,
  input  logic                   pronto,
  output logic [3:0]             botoes,
  output logic                   ocupado,
  output logic [2:0]             db_estado,
  output logic [$clog2(DEPTH):0] db_contagem
);

  localparam int AW = largura(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = largura(maior3(PRESS_CYCLES, GAP_CYCLES, IDLE_CYCLES));

  estado_t       estado_q, estado_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    leds_ant_q, leds_ant_d;
  logic [3:0]    botoes_q, botoes_d;
  logic          ocupado_q, ocupado_d;
  logic          we;
  logic [3:0]    dado_lido;

  memoria_jogadas #(.DEPTH(DEPTH), .AW(AW)) u_memoria (
    .clock            (clock),
    .we               (we),
    .endereco_escrita (count_q[AW-1:0]),
    .dado             (leds),
    .endereco_leitura (idx_d),
    .dado_lido        (dado_lido)
  );

  always_comb begin
    estado_d   = estado_q;
    count_d    = count_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    leds_ant_d = leds;
    we         = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (habilita) begin
          estado_d = OBSERVA;
          count_d  = '0;
          timer_d  = '0;
        end
      end
      default: begin
        if (!habilita) begin
          estado_d = OCIOSO;
        end else if (pronto) begin
          estado_d = FIM;
        end else begin
          case (estado_q)
            OBSERVA: begin
              // Only a rise from a dark display counts as a new pattern.
              if (leds != 4'd0) begin
                timer_d = '0;
                if (leds_ant_q == 4'd0 && count_q != CW'(DEPTH)) begin
                  we      = 1'b1;
                  count_d = count_q + CW'(1);
                end
              end else if (count_q != '0) begin
                if (timer_q == TW'(IDLE_CYCLES - 1)) begin
                  estado_d = PRESSIONA;
                  idx_d    = '0;
                  timer_d  = '0;
                end else begin
                  timer_d = timer_q + TW'(1);
                end
              end
            end
            PRESSIONA: begin
              if (timer_q == TW'(PRESS_CYCLES - 1)) begin
                estado_d = SOLTA;
                timer_d  = '0;
              end else begin
                timer_d = timer_q + TW'(1);
              end
            end
            SOLTA: begin
              if (timer_q == TW'(GAP_CYCLES - 1)) begin
                timer_d = '0;
                if ({1'b0, idx_q} == count_q - CW'(1)) begin
                  estado_d = OBSERVA;
                  count_d  = '0;
                end else begin
                  estado_d = PRESSIONA;
                  idx_d    = idx_q + AW'(1);
                end
              end else begin
                timer_d = timer_q + TW'(1);
              end
            end
            default: ;
          endcase
        end
      end
    endcase
    botoes_d  = (estado_d == PRESSIONA) ? dado_lido : 4'd0;
    ocupado_d = (estado_d == PRESSIONA) || (estado_d == SOLTA);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      count_q    <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      leds_ant_q <= 4'd0;
      botoes_q   <= 4'd0;
      ocupado_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      leds_ant_q <= leds_ant_d;
      botoes_q   <= botoes_d;
      ocupado_q  <= ocupado_d;
    end
  end

  assign botoes      = botoes_q;
  assign ocupado     = ocupado_q;
  assign db_estado   = estado_q;
  assign db_contagem = count_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// tb/tb_jogador_automatico.sv - vector table, directed corners and randomized rounds for jogador_automatico
module tb_jogador_automatico;

  localparam int DEPTH = 16;
  localparam int PRESS = 4;
  localparam int GAP   = 4;
  localparam int IDLE  = 8;
  localparam int DC    = 99;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       habilita = 1'b0;
  logic [3:0] leds = 4'd0;
  logic       pronto = 1'b0;
  logic [3:0] botoes;
  logic       ocupado;
  logic [2:0] db_estado;
  logic [4:0] db_contagem;

  int n_ok = 0;
  int n_tot = 0;

  jogador_automatico #(
    .DEPTH(DEPTH), .PRESS_CYCLES(PRESS), .GAP_CYCLES(GAP), .IDLE_CYCLES(IDLE)
  ) dut (
    .clock(clock), .reset(reset), .habilita(habilita), .leds(leds), .pronto(pronto),
    .botoes(botoes), .ocupado(ocupado), .db_estado(db_estado), .db_contagem(db_contagem)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       hab;
    logic       pron;
    logic [3:0] leds;
    int         ciclos;
    int         botoes;
    int         estado;
    int         contagem;
  } seg_t;

  seg_t tab[$];

  task automatic chk(input string nome, input int act, input int exp);
    n_tot++;
    if (act == exp) n_ok++;
    else $display("FAIL %s: got %0d expected %0d", nome, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_saidas(input string nome, input int b, input int e, input int c);
    chk({nome, ".botoes"}, int'(botoes), b);
    chk({nome, ".estado"}, int'(db_estado), e);
    chk({nome, ".ocupado"}, int'(ocupado), (e == 2 || e == 3) ? 1 : 0);
    if (c != DC) chk({nome, ".contagem"}, int'(db_contagem), c);
  endtask

  task automatic add(input logic h, input logic p, input logic [3:0] l, input int n,
                     input int b, input int e, input int c);
    seg_t s;
    s = '{hab: h, pron: p, leds: l, ciclos: n, botoes: b, estado: e, contagem: c};
    tab.push_back(s);
  endtask

  // One round at a higher level: the list of shown patterns is the model; replay must
  // start IDLE dark cycles after the last pattern and emit the first DEPTH of them.
  task automatic rodada(input int n, input string nome);
    logic [3:0] pats[$];
    logic [3:0] p;
    int m;
    repeat ($urandom_range(0, 6)) begin
      leds = 4'd0;
      step();
      chk_saidas({nome, ".espera"}, 0, 1, 0);
    end
    for (int i = 0; i < n; i++) begin
      p = 4'($urandom_range(1, 15));
      pats.push_back(p);
      leds = p;
      step();
      chk_saidas({nome, ".captura"}, 0, 1, (i + 1 < DEPTH) ? i + 1 : DEPTH);
      repeat ($urandom_range(0, 3)) begin
        leds = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : p;
        step();
        chk_saidas({nome, ".segura"}, 0, 1, (i + 1 < DEPTH) ? i + 1 : DEPTH);
      end
      if (i < n - 1) begin
        leds = 4'd0;
        repeat ($urandom_range(1, IDLE - 1)) begin
          step();
          chk_saidas({nome, ".pausa"}, 0, 1, DC);
        end
      end
    end
    m = (n < DEPTH) ? n : DEPTH;
    leds = 4'd0;
    repeat (IDLE - 1) begin
      step();
      chk_saidas({nome, ".ocioso"}, 0, 1, m);
    end
    for (int k = 0; k < m; k++) begin
      for (int j = 0; j < PRESS + GAP; j++) begin
        step();
        if (j < PRESS) chk_saidas($sformatf("%s.press%0d", nome, k), int'(pats[k]), 2, DC);
        else           chk_saidas($sformatf("%s.gap%0d", nome, k), 0, 3, DC);
        leds = (k == m - 1 && j == PRESS + GAP - 1) ? 4'd0 : 4'($urandom_range(0, 15));
      end
    end
    leds = 4'd0;
    step();
    chk_saidas({nome, ".fim"}, 0, 1, 0);
  endtask

  initial begin
    // Capture and replay of 0001 / 0100.
    add(1, 0, 4'h0, 1, 0, 1, 0);
    add(1, 0, 4'h1, 5, 0, 1, 1);
    add(1, 0, 4'h0, 3, 0, 1, 1);
    add(1, 0, 4'h4, 5, 0, 1, 2);
    add(1, 0, 4'h0, 7, 0, 1, 2);
    add(1, 0, 4'h0, 4, 1, 2, 2);
    add(1, 0, 4'h0, 4, 0, 3, 2);
    add(1, 0, 4'h0, 4, 4, 2, 2);
    add(1, 0, 4'h0, 4, 0, 3, 2);
    add(1, 0, 4'h0, 1, 0, 1, 0);
    // Short blank keeps both captures; pronto during the second press.
    add(1, 0, 4'h2, 2, 0, 1, 1);
    add(1, 0, 4'h0, 7, 0, 1, 1);
    add(1, 0, 4'h8, 2, 0, 1, 2);
    add(1, 0, 4'h0, 7, 0, 1, 2);
    add(1, 0, 4'h0, 4, 2, 2, 2);
    add(1, 0, 4'h0, 4, 0, 3, 2);
    add(1, 0, 4'h0, 1, 8, 2, 2);
    add(1, 1, 4'h0, 1, 0, 4, DC);
    add(1, 0, 4'h0, 3, 0, 4, DC);
    add(0, 0, 4'h0, 2, 0, 0, DC);
    // Drop habilita with three captures, non-one-hot and non-edge changes included.
    add(1, 0, 4'h0, 1, 0, 1, 0);
    add(1, 0, 4'h3, 1, 0, 1, 1);
    add(1, 0, 4'h0, 1, 0, 1, 1);
    add(1, 0, 4'h5, 1, 0, 1, 2);
    add(1, 0, 4'h6, 1, 0, 1, 2);
    add(1, 0, 4'h0, 1, 0, 1, 2);
    add(1, 0, 4'h9, 1, 0, 1, 3);
    add(0, 0, 4'h9, 1, 0, 0, DC);
    add(1, 0, 4'h0, 1, 0, 1, 0);
    add(1, 0, 4'h0, 20, 0, 1, 0);

    #1;
    chk_saidas("reset_t0", 0, 0, 0);
    step();
    step();
    chk_saidas("reset", 0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < tab.size(); i++) begin
      habilita = tab[i].hab;
      pronto   = tab[i].pron;
      leds     = tab[i].leds;
      for (int c = 0; c < tab[i].ciclos; c++) begin
        step();
        chk_saidas($sformatf("seg%0d", i), tab[i].botoes, tab[i].estado, tab[i].contagem);
      end
    end

    // Asynchronous reset while pressing 0100.
    habilita = 1'b1;
    pronto   = 1'b0;
    leds     = 4'h4;
    step();
    leds = 4'h0;
    repeat (IDLE) step();
    chk_saidas("pre_reset", 4, 2, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_saidas("reset_async", 0, 0, 0);
    reset = 1'b0;
    step();
    chk_saidas("pos_reset", 0, 1, 0);

    rodada(18, "saturacao");
    for (int r = 0; r < 10; r++) rodada($urandom_range(1, 20), $sformatf("rnd%0d", r));

    $display("%0d/%0d checks passed", n_ok, n_tot);
    $finish;
  end

endmodule
